bsg_idiv_frontend: RTL and testbench
====================================

Name: bsg_idiv_frontend

Overview:
Request-side stage that sits directly upstream of the iterative integer divider and feeds it.
- Accepts RISC-V style divide ops (DIV/DIVU/REM/REMU).
- Resolves divide-by-zero, signed overflow and repeated-operand cases locally, without invoking the divider.
- Issues all other requests to the divider, consumes its quotient/remainder, and returns the single selected result word to the consumer.

Parameters:
- width_p, 32, operand/result width in bits.
- cache_en_p, 1, when 1 a one-entry last-operands result cache is present; when 0 cache hit is forced to 0.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  1  request valid.
- ready_and_o  out  1  frontend can accept a request.
- op_i  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU.
- dividend_i  in  width_p  dividend.
- divisor_i  in  width_p  divisor.
- cache_clr_i  in  1  invalidate result cache.
- div_v_o  out  1  request to divider.
- div_ready_and_i  in  1  divider idle/accepting.
- div_dividend_o  out  width_p  divider dividend.
- div_divisor_o  out  width_p  divider divisor.
- div_signed_o  out  1  divider signed select.
- div_v_i  in  1  divider result valid.
- div_quotient_i  in  width_p  divider quotient.
- div_remainder_i  in  width_p  divider remainder.
- div_yumi_o  out  1  divider result consumed.
- v_o  out  1  result valid.
- data_o  out  width_p  quotient (op 0/1) or remainder (op 2/3).
- yumi_i  in  1  consumer takes result.

Behaviour:
Decode:
- signed = ~op_i[0]; sel_rem = op_i[1].
- Operands, signed and sel_rem are latched into registers on accept (v_i & ready_and_o).

Fast-path classes, evaluated on the request inputs in priority order:
- Zero divisor (divisor==0): q = all ones, r = dividend.
- Overflow (signed, dividend = 1 followed by zeros, divisor = all ones): q = dividend, r = 0.
- Cache hit (cache valid, dividend, divisor and signed all equal the cached tag): q/r = cached values.

State machine {IDLE, ISSUE, WAIT, RESP}:
- IDLE: ready_and_o=1. On accept, go to RESP if any fast-path class matches (q/r written into the result register), otherwise go to ISSUE.
- ISSUE: div_v_o=1, driven from the latched operands. Move to WAIT on div_ready_and_i. div_* outputs stay stable while div_v_o=1.
- WAIT: div_yumi_o = div_v_i. When div_v_i is high:
  - q/r are latched into the result register;
  - the cache is written with tag and q/r (if cache_en_p);
  - the FSM goes to RESP.
- RESP: v_o=1. data_o is the stored q if sel_rem=0, else r, and is held stable. On yumi_i, go to IDLE. No request is accepted in the same cycle as yumi_i; ready_and_o rises the following cycle.

Latency:
- Fast path: accept in cycle N, v_o in cycle N+1.
- Divider path: div_v_o from N+1, v_o the cycle after div_v_i is seen.

Cache:
- Single entry; valid clears on reset and on cache_clr_i.
- If cache_clr_i and a cache write occur in the same cycle, the clear wins (entry invalid).
- If cache_clr_i is asserted in the same cycle as an accept, the hit check uses the pre-clear valid bit.
- Zero-divisor and overflow results are never written to the cache.

Reset:
- All outputs are 0 during and after reset: v_o, div_v_o, div_yumi_o, data_o, div_* data.
- ready_and_o=1 from the first cycle after reset is deasserted.
- Reset mid-operation returns the FSM to IDLE and discards any in-flight result. The divider is reset by the same reset_i.

Other:
- div_yumi_o is never asserted outside WAIT.
- div_v_i outside WAIT is ignored.

Decomposition:
- Shared package bsg_idiv_pkg holds:
  - the 2-bit op enum (e_div, e_divu, e_rem, e_remu);
  - the FSM state enum;
  - a helper constant for the signed minimum value derived from width_p.
- One combinational sub-module, bsg_idiv_special_case: inputs are dividend, divisor, signed, cache tag/valid/values; outputs are is_zero, is_ovf, is_hit, fast q/r.

Test Plan:
1. DIV 7 / 0 -> no div_v_o; v_o in cycle N+1 with data_o=0xFFFFFFFF. REM 7 / 0 -> data_o=7.
2. DIV 0x80000000 / 0xFFFFFFFF -> data_o=0x80000000, no divider issue. REM of the same -> 0. DIVU of the same -> div_v_o issued; model returns q=0, data_o=0.
3. DIV -7 / 2 via divider model (q=-3, r=-1), then REM -7 / 2 -> second request hits the cache: no div_v_o, data_o=0xFFFFFFFF in N+1.
4. Same sequence as 3 with cache_clr_i pulsed between the two requests -> second request issues to the divider. Clear coincident with the divider result write -> the next identical request misses.
5. Backpressure: hold div_ready_and_i=0 for 5 cycles and yumi_i=0 for 3 cycles -> div_* outputs and data_o stay stable; exactly one div_yumi_o pulse; ready_and_o=0 throughout.
6. Assert reset_i while in WAIT with div_v_i pending -> next cycle IDLE, v_o=0, div_yumi_o=0. A new DIVU 100/7 then completes with data_o=14.

Source files
------------

// File: rtl/bsg_idiv_pkg.sv
// Shared types for the integer-divide frontend: op encoding, FSM states and width helpers.
package bsg_idiv_pkg;

  typedef enum logic [1:0] {
    e_div  = 2'd0,
    e_divu = 2'd1,
    e_rem  = 2'd2,
    e_remu = 2'd3
  } bsg_idiv_op_e;

  typedef enum logic [1:0] {
    e_idle,
    e_issue,
    e_wait,
    e_resp
  } bsg_idiv_state_e;

  localparam int idiv_max_width_gp = 64;

  // Most negative two's-complement value of the given width, zero-extended to the max width.
  function automatic logic [idiv_max_width_gp-1:0] idiv_signed_min(input int width);
    return idiv_max_width_gp'(1) << (width - 1);
  endfunction

  function automatic logic idiv_op_is_signed(input bsg_idiv_op_e op);
    return (op == e_div) || (op == e_rem);
  endfunction

  function automatic logic idiv_op_is_rem(input bsg_idiv_op_e op);
    return (op == e_rem) || (op == e_remu);
  endfunction

endpackage

// File: rtl/bsg_idiv_frontend_if.sv
// Bundles the request, divider and response channels of the divide frontend.
interface bsg_idiv_frontend_if #(
  parameter int width_p = 32
);

  logic               v_i;
  logic               ready_and_o;
  logic [1:0]         op_i;
  logic [width_p-1:0] dividend_i;
  logic [width_p-1:0] divisor_i;
  logic               cache_clr_i;

  logic               div_v_o;
  logic               div_ready_and_i;
  logic [width_p-1:0] div_dividend_o;
  logic [width_p-1:0] div_divisor_o;
  logic               div_signed_o;
  logic               div_v_i;
  logic [width_p-1:0] div_quotient_i;
  logic [width_p-1:0] div_remainder_i;
  logic               div_yumi_o;

  logic               v_o;
  logic [width_p-1:0] data_o;
  logic               yumi_i;

  // The frontend masters the divider and the result channel.
  modport master (
    input  v_i, op_i, dividend_i, divisor_i, cache_clr_i,
    input  div_ready_and_i, div_v_i, div_quotient_i, div_remainder_i,
    input  yumi_i,
    output ready_and_o, div_v_o, div_dividend_o, div_divisor_o, div_signed_o,
    output div_yumi_o, v_o, data_o
  );

  modport slave (
    output v_i, op_i, dividend_i, divisor_i, cache_clr_i,
    output div_ready_and_i, div_v_i, div_quotient_i, div_remainder_i,
    output yumi_i,
    input  ready_and_o, div_v_o, div_dividend_o, div_divisor_o, div_signed_o,
    input  div_yumi_o, v_o, data_o
  );

endinterface

// File: rtl/bsg_idiv_special_case.sv
// Classifies a divide request into zero-divisor, signed-overflow or cache-hit fast paths
// and produces the quotient/remainder for whichever class wins.
module bsg_idiv_special_case
  import bsg_idiv_pkg::*;
#(
  parameter int width_p    = 32,
  parameter bit cache_en_p = 1'b1
) (
  input  logic [width_p-1:0] dividend_i,
  input  logic [width_p-1:0] divisor_i,
  input  logic               signed_i,

  input  logic               cache_v_i,
  input  logic [width_p-1:0] cache_dividend_i,
  input  logic [width_p-1:0] cache_divisor_i,
  input  logic               cache_signed_i,
  input  logic [width_p-1:0] cache_quotient_i,
  input  logic [width_p-1:0] cache_remainder_i,

  output logic               is_zero_o,
  output logic               is_ovf_o,
  output logic               is_hit_o,
  output logic [width_p-1:0] fast_quotient_o,
  output logic [width_p-1:0] fast_remainder_o
);

  localparam logic [idiv_max_width_gp-1:0] signed_min_wide_lp = idiv_signed_min(width_p);
  localparam logic [width_p-1:0]           signed_min_lp      = signed_min_wide_lp[width_p-1:0];

  logic tag_match;

  assign tag_match = cache_v_i
                  && (dividend_i == cache_dividend_i)
                  && (divisor_i  == cache_divisor_i)
                  && (signed_i   == cache_signed_i);

  // Zero divisor outranks overflow, which outranks a cache hit.
  always_comb begin
    is_zero_o        = 1'b0;
    is_ovf_o         = 1'b0;
    is_hit_o         = 1'b0;
    fast_quotient_o  = '0;
    fast_remainder_o = '0;

    if (divisor_i == '0) begin
      is_zero_o        = 1'b1;
      fast_quotient_o  = '1;
      fast_remainder_o = dividend_i;
    end else if (signed_i && (dividend_i == signed_min_lp) && (divisor_i == '1)) begin
      is_ovf_o         = 1'b1;
      fast_quotient_o  = dividend_i;
      fast_remainder_o = '0;
    end else if (cache_en_p && tag_match) begin
      is_hit_o         = 1'b1;
      fast_quotient_o  = cache_quotient_i;
      fast_remainder_o = cache_remainder_i;
    end
  end

endmodule

// File: rtl/bsg_idiv_frontend.sv
// Request-side frontend of the iterative divider: resolves trivial cases locally,
// otherwise issues to the divider and returns the selected quotient or remainder.
module bsg_idiv_frontend
  import bsg_idiv_pkg::*;
#(
  parameter int width_p    = 32,
  parameter bit cache_en_p = 1'b1
) (
  input logic                 clk_i,
  input logic                 reset_i,
  bsg_idiv_frontend_if.master io
);

  bsg_idiv_state_e    state_q, state_d;
  logic [width_p-1:0] dividend_q, dividend_d;
  logic [width_p-1:0] divisor_q, divisor_d;
  logic               signed_q, signed_d;
  logic               sel_rem_q, sel_rem_d;
  logic [width_p-1:0] quotient_q, quotient_d;
  logic [width_p-1:0] remainder_q, remainder_d;

  logic               cache_v_q, cache_v_d;
  logic [width_p-1:0] cache_dividend_q, cache_dividend_d;
  logic [width_p-1:0] cache_divisor_q, cache_divisor_d;
  logic               cache_signed_q, cache_signed_d;
  logic [width_p-1:0] cache_quotient_q, cache_quotient_d;
  logic [width_p-1:0] cache_remainder_q, cache_remainder_d;

  bsg_idiv_op_e       op_li;
  logic               req_signed_li;
  logic               req_rem_li;
  logic               cache_we_li;
  logic               ready_lo, div_v_lo, div_yumi_lo, v_lo;

  logic               is_zero_lo, is_ovf_lo, is_hit_lo;
  logic [width_p-1:0] fast_quotient_lo, fast_remainder_lo;

  assign op_li         = bsg_idiv_op_e'(io.op_i);
  assign req_signed_li = idiv_op_is_signed(op_li);
  assign req_rem_li    = idiv_op_is_rem(op_li);

  bsg_idiv_special_case #(
    .width_p    (width_p),
    .cache_en_p (cache_en_p)
  ) special (
    .dividend_i        (io.dividend_i),
    .divisor_i         (io.divisor_i),
    .signed_i          (req_signed_li),
    .cache_v_i         (cache_v_q),
    .cache_dividend_i  (cache_dividend_q),
    .cache_divisor_i   (cache_divisor_q),
    .cache_signed_i    (cache_signed_q),
    .cache_quotient_i  (cache_quotient_q),
    .cache_remainder_i (cache_remainder_q),
    .is_zero_o         (is_zero_lo),
    .is_ovf_o          (is_ovf_lo),
    .is_hit_o          (is_hit_lo),
    .fast_quotient_o   (fast_quotient_lo),
    .fast_remainder_o  (fast_remainder_lo)
  );

  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    signed_d    = signed_q;
    sel_rem_d   = sel_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ready_lo    = 1'b0;
    div_v_lo    = 1'b0;
    div_yumi_lo = 1'b0;
    v_lo        = 1'b0;
    cache_we_li = 1'b0;

    unique case (state_q)
      e_idle: begin
        ready_lo = 1'b1;
        if (io.v_i) begin
          dividend_d = io.dividend_i;
          divisor_d  = io.divisor_i;
          signed_d   = req_signed_li;
          sel_rem_d  = req_rem_li;
          if (is_zero_lo || is_ovf_lo || is_hit_lo) begin
            quotient_d  = fast_quotient_lo;
            remainder_d = fast_remainder_lo;
            state_d     = e_resp;
          end else begin
            state_d = e_issue;
          end
        end
      end
      e_issue: begin
        div_v_lo = 1'b1;
        if (io.div_ready_and_i) state_d = e_wait;
      end
      e_wait: begin
        div_yumi_lo = io.div_v_i;
        if (io.div_v_i) begin
          quotient_d  = io.div_quotient_i;
          remainder_d = io.div_remainder_i;
          cache_we_li = cache_en_p;
          state_d     = e_resp;
        end
      end
      e_resp: begin
        v_lo = 1'b1;
        if (io.yumi_i) state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase
  end

  // A clear arriving with a write leaves the entry invalid.
  always_comb begin
    cache_v_d         = cache_v_q;
    cache_dividend_d  = cache_dividend_q;
    cache_divisor_d   = cache_divisor_q;
    cache_signed_d    = cache_signed_q;
    cache_quotient_d  = cache_quotient_q;
    cache_remainder_d = cache_remainder_q;

    if (cache_we_li) begin
      cache_v_d         = 1'b1;
      cache_dividend_d  = dividend_q;
      cache_divisor_d   = divisor_q;
      cache_signed_d    = signed_q;
      cache_quotient_d  = io.div_quotient_i;
      cache_remainder_d = io.div_remainder_i;
    end
    if (io.cache_clr_i) cache_v_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_idle;
      dividend_q  <= '0;
      divisor_q   <= '0;
      signed_q    <= 1'b0;
      sel_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      signed_q    <= signed_d;
      sel_rem_q   <= sel_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cache_v_q         <= 1'b0;
      cache_dividend_q  <= '0;
      cache_divisor_q   <= '0;
      cache_signed_q    <= 1'b0;
      cache_quotient_q  <= '0;
      cache_remainder_q <= '0;
    end else begin
      cache_v_q         <= cache_v_d;
      cache_dividend_q  <= cache_dividend_d;
      cache_divisor_q   <= cache_divisor_d;
      cache_signed_q    <= cache_signed_d;
      cache_quotient_q  <= cache_quotient_d;
      cache_remainder_q <= cache_remainder_d;
    end
  end

  // Outputs are forced low while reset is held so nothing leaks from a discarded operation.
  assign io.ready_and_o    = ready_lo & ~reset_i;
  assign io.div_v_o        = div_v_lo & ~reset_i;
  assign io.div_yumi_o     = div_yumi_lo & ~reset_i;
  assign io.v_o            = v_lo & ~reset_i;
  assign io.div_dividend_o = reset_i ? '0 : dividend_q;
  assign io.div_divisor_o  = reset_i ? '0 : divisor_q;
  assign io.div_signed_o   = signed_q & ~reset_i;
  assign io.data_o         = reset_i ? '0 : (sel_rem_q ? remainder_q : quotient_q);

endmodule

// File: tb/tb_bsg_idiv_frontend.sv
// Randomized bench for bsg_idiv_frontend: a behavioural divider and a RISC-V divide
// reference with a one-entry cache model predict every result, issue and latency.
module tb_bsg_idiv_frontend;
  import bsg_idiv_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   yumi_pulses = 0;

  bit          mc_v;
  logic [31:0] mc_a, mc_b;
  bit          mc_s;

  always #5 clk = ~clk;

  bsg_idiv_frontend_if #(.width_p(32)) io();

  bsg_idiv_frontend #(
    .width_p    (32),
    .cache_en_p (1'b1)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .io      (io)
  );

  always @(negedge clk) begin
    #2;
    if (io.div_yumi_o) yumi_pulses++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // RISC-V divide semantics, including the two architecturally defined corner cases.
  function automatic void ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else if (!op[0]) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic applyReset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    checkOutput("rst_v_o", io.v_o, 0);
    checkOutput("rst_div_v_o", io.div_v_o, 0);
    checkOutput("rst_div_yumi_o", io.div_yumi_o, 0);
    checkOutput("rst_data_o", io.data_o, 0);
    checkOutput("rst_div_dividend_o", io.div_dividend_o, 0);
    reset = 1'b0;
    #1;
    checkOutput("rst_ready_after", io.ready_and_o, 1);
    mc_v = 1'b0;
  endtask

  task automatic pulseClear();
    io.cache_clr_i = 1'b1;
    @(negedge clk);
    io.cache_clr_i = 1'b0;
    mc_v = 1'b0;
  endtask

  // clr_mode: 0 none, 1 clear with the accept, 2 clear with the divider result.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int stall, input int lat, input int hold, input int clr_mode);
    logic [31:0] q, r, exp, dq, dr, d_a, d_b;
    bit sgn, hit, fast, busy, rsp, stable, rdy_bad, hold_ok, d_s;
    int t, issued, y0, exp_t;

    ref_div(op, a, b, q, r);
    exp   = op[1] ? r : q;
    sgn   = !op[0];
    hit   = mc_v && mc_a == a && mc_b == b && mc_s == sgn;
    fast  = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || hit;
    exp_t = stall + lat + 2;

    t = 0;
    while (!io.ready_and_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    checkOutput("ready_at_req", io.ready_and_o, 1);
    io.v_i         = 1'b1;
    io.op_i        = op;
    io.dividend_i  = a;
    io.divisor_i   = b;
    io.cache_clr_i = (clr_mode == 1);
    y0 = yumi_pulses;
    @(negedge clk);
    io.v_i         = 1'b0;
    io.cache_clr_i = 1'b0;
    io.op_i        = 2'($urandom);
    io.dividend_i  = $urandom;
    io.divisor_i   = $urandom;

    if (clr_mode == 1) mc_v = 1'b0;
    if (!fast) begin
      mc_v = (clr_mode != 2);
      mc_a = a;
      mc_b = b;
      mc_s = sgn;
    end

    busy = 0; rsp = 0; issued = 0; stable = 1; rdy_bad = 0; t = 0;
    while (!io.v_o && t < 100) begin
      if (io.ready_and_o) rdy_bad = 1;
      if (io.div_v_o && (io.div_dividend_o !== a || io.div_divisor_o !== b || io.div_signed_o !== sgn))
        stable = 0;
      if (!busy) begin
        if (io.div_v_o) begin
          if (stall > 0) begin
            io.div_ready_and_i = 1'b0;
            stall--;
          end else begin
            io.div_ready_and_i = 1'b1;
            busy = 1;
            issued++;
            d_a = io.div_dividend_o;
            d_b = io.div_divisor_o;
            d_s = io.div_signed_o;
          end
        end
      end else if (!rsp) begin
        io.div_ready_and_i = 1'b0;
        if (lat > 0) lat--;
        else begin
          ref_div({1'b0, ~d_s}, d_a, d_b, dq, dr);
          io.div_v_i         = 1'b1;
          io.div_quotient_i  = dq;
          io.div_remainder_i = dr;
          io.cache_clr_i     = (clr_mode == 2);
          rsp = 1;
        end
      end
      @(negedge clk);
      t++;
      io.cache_clr_i = 1'b0;
    end
    io.div_ready_and_i = 1'b0;

    checkOutput("v_o", io.v_o, 1);
    checkOutput("issued", issued, fast ? 0 : 1);
    checkOutput("latency", t, fast ? 0 : exp_t);
    checkOutput("data", io.data_o, exp);
    checkOutput("div_v_o_in_resp", io.div_v_o, 0);
    checkOutput("div_stable", stable, 1);
    checkOutput("ready_low_busy", rdy_bad, 0);

    // div_v_i stays high during the hold to confirm it is ignored outside the wait state.
    hold_ok = 1;
    repeat (hold) begin
      if (io.data_o !== exp || io.v_o !== 1'b1 || io.ready_and_o !== 1'b0) hold_ok = 0;
      @(negedge clk);
    end
    checkOutput("resp_hold", hold_ok, 1);
    io.yumi_i = 1'b1;
    checkOutput("ready_in_yumi", io.ready_and_o, 0);
    @(negedge clk);
    io.yumi_i  = 1'b0;
    io.div_v_i = 1'b0;
    checkOutput("v_o_after_yumi", io.v_o, 0);
    checkOutput("ready_after_yumi", io.ready_and_o, 1);
    checkOutput("yumi_pulses", yumi_pulses - y0, issued);
  endtask

  task automatic resetInWait();
    checkOutput("t6_ready", io.ready_and_o, 1);
    io.v_i        = 1'b1;
    io.op_i       = e_div;
    io.dividend_i = 32'd1000;
    io.divisor_i  = 32'd3;
    @(negedge clk);
    io.v_i = 1'b0;
    checkOutput("t6_issue", io.div_v_o, 1);
    io.div_ready_and_i = 1'b1;
    @(negedge clk);
    io.div_ready_and_i = 1'b0;
    io.div_v_i         = 1'b1;
    io.div_quotient_i  = 32'd333;
    io.div_remainder_i = 32'd1;
    reset = 1'b1;
    #2;
    checkOutput("t6_yumi_in_reset", io.div_yumi_o, 0);
    checkOutput("t6_v_in_reset", io.v_o, 0);
    @(negedge clk);
    reset      = 1'b0;
    io.div_v_i = 1'b0;
    #1;
    checkOutput("t6_ready_after", io.ready_and_o, 1);
    checkOutput("t6_v_after", io.v_o, 0);
    checkOutput("t6_div_v_after", io.div_v_o, 0);
    mc_v = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a, b, last_a, last_b;
    logic [1:0]  op;
    int          kind;

    io.v_i = 0; io.op_i = 0; io.dividend_i = 0; io.divisor_i = 0; io.cache_clr_i = 0;
    io.div_ready_and_i = 0; io.div_v_i = 0; io.div_quotient_i = 0; io.div_remainder_i = 0;
    io.yumi_i = 0;
    mc_v = 0; mc_a = 0; mc_b = 0; mc_s = 0;

    applyReset(3);

    applyStimulus(e_div,  32'd7, 32'd0, 0, 0, 0, 0);
    applyStimulus(e_rem,  32'd7, 32'd0, 0, 0, 1, 0);
    applyStimulus(e_div,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
    applyStimulus(e_rem,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
    applyStimulus(e_divu, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 0, 0);
    applyStimulus(e_div,  32'hFFFF_FFF9, 32'd2, 0, 2, 0, 0);
    applyStimulus(e_rem,  32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0);
    pulseClear();
    applyStimulus(e_rem,  32'hFFFF_FFF9, 32'd2, 1, 1, 0, 0);
    applyStimulus(e_div,  32'd21, 32'd4, 0, 1, 0, 2);
    applyStimulus(e_div,  32'd21, 32'd4, 0, 0, 0, 0);
    applyStimulus(e_div,  32'd21, 32'd4, 0, 0, 0, 1);
    applyStimulus(e_rem,  32'd21, 32'd4, 0, 0, 0, 0);
    applyStimulus(e_divu, 32'd1000, 32'd33, 5, 3, 3, 0);
    resetInWait();
    applyStimulus(e_divu, 32'd100, 32'd7, 0, 2, 0, 0);

    last_a = 32'd100;
    last_b = 32'd7;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      op   = 2'($urandom_range(0, 3));
      case (kind)
        0: begin a = $urandom; b = $urandom; end
        1: begin
          a = 32'($urandom_range(0, 200)) - 32'd100;
          b = 32'($urandom_range(1, 20));
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        2: begin a = $urandom; b = 32'd0; end
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: begin a = last_a; b = last_b; end
      endcase
      applyStimulus(op, a, b, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2),
                    ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0);
      if ($urandom_range(0, 9) == 0) pulseClear();
      last_a = a;
      last_b = b;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
